instr_mem_loader: RTL and testbench

Boot loader stage directly upstream of the 256×32 single-port on-chip instruction memory. It accepts a byte stream from a host link (UART/JTAG bridge), packs bytes little-endian into 32-bit words, and writes them through the memory's Avalon-MM slave port. It holds the attached processor in reset until a complete image has landed.

---
 rtl/instr_loader_pkg.sv | 31 +++
 rtl/instr_loader_packer.sv | 47 ++++
 rtl/instr_mem_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Contents:
//   state_e        - loader FSM state encoding
//   BYTE_LANES     - bytes per memory word
//   WORD_W         - memory word width
//   BYTEENABLE_ALL - constant byteenable driven to the memory
//   chk_add        - mod-256 running sum step for the optional image checksum
package instr_loader_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WORD_W     = 32;

  localparam logic [BYTE_LANES-1:0] BYTEENABLE_ALL = 4'b1111;

  // ST_CHK is only reachable when the checksum trailer is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5,
    ST_CHK  = 3'd6
  } state_e;

  // One step of the mod-256 image checksum (carry out is discarded).
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/instr_loader_packer.sv
// Little-endian byte-to-word packer for the instruction memory loader.
// The first byte of a word ends up in bits [7:0], the fourth in [31:24].
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear         - synchronous clear of lanes and lane counter (driven by the FSM)
//   byte_valid    - a byte is being accepted this cycle
//   byte_in       - the byte being accepted
//   word_valid    - this cycle's byte completes a word (combinational)
//   word          - the completed word, valid together with word_valid
module instr_loader_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int LANE_W = $clog2(BYTE_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTE_LANES - 1);

  // Only the first three bytes need storage; the fourth is taken straight
  // from byte_in when the word is emitted.
  logic [WORD_W-9:0] lanes_r;
  logic [LANE_W-1:0] lane_cnt_r;

  // Shift new bytes in from the top so earlier bytes drift to lower lanes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lanes_r    <= '0;
      lane_cnt_r <= '0;
    end else if (clear) begin
      lanes_r    <= '0;
      lane_cnt_r <= '0;
    end else if (byte_valid) begin
      lanes_r    <= {byte_in, lanes_r[WORD_W-9:8]};
      lane_cnt_r <= lane_cnt_r + LANE_W'(1);
    end
  end

  assign word_valid = byte_valid & (lane_cnt_r == LAST_LANE);
  assign word       = {byte_in, lanes_r};

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader in front of a single-port instruction memory (Avalon-MM write
// side). Receives LEN followed by 4*(LEN+1) bytes, packs them little-endian
// and writes one word per WR cycle at consecutive addresses from 0. The
// processor is held in reset (cpu_hold) until an image has fully landed.
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailer byte
// equal to the mod-256 sum of all data bytes; a mismatch ends in ERR.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start                 - begin a load (honoured in IDLE, DONE, ERR)
//   in_data/in_valid      - byte stream from the host link
//   in_ready              - loader accepts a byte this cycle
//   mem_address           - word address
//   mem_writedata         - packed word
//   mem_byteenable        - constant all-ones
//   mem_chipselect/write  - one-cycle write strobe
//   mem_clken             - constant 1
//   cpu_hold              - processor reset request, low only in DONE
//   load_done/load_error  - sticky status until the next accepted start
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [WORD_W-1:0]     mem_writedata,
  output logic [BYTE_LANES-1:0] mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // LEN values at or above the depth would need the address to wrap.
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] len_r;
  logic              accept_s;
  logic              len_bad_s;
  logic              last_word_s;
  logic              pack_clear_s;
  logic              pack_byte_s;
  logic              word_valid_s;
  logic [WORD_W-1:0] word_s;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r;
`endif

  assign accept_s     = in_valid & in_ready;
  assign len_bad_s    = ({1'b0, in_data} >= DEPTH);
  assign last_word_s  = (mem_address == len_r);
  assign pack_clear_s = (state_r == ST_LEN);
  assign pack_byte_s  = accept_s & (state_r == ST_DATA);

  assign mem_byteenable = BYTEENABLE_ALL;
  assign mem_clken      = 1'b1;

  instr_loader_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear_s),
    .byte_valid (pack_byte_s),
    .byte_in    (in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state logic for the load sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LEN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LEN: begin
        if (accept_s) begin
          if (len_bad_s) state_nxt_s = ST_ERR;
          else           state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (word_valid_s) state_nxt_s = ST_WR;
        else              state_nxt_s = ST_DATA;
      end
      ST_WR: begin
        if (last_word_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_nxt_s = ST_CHK;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          if (in_data == sum_r) state_nxt_s = ST_DONE;
          else                  state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_CHK;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start) state_nxt_s = ST_LEN;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and all registered outputs, derived from the next state
  // so each output is valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      in_ready       <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      len_r          <= '0;
    end else begin
      state_r        <= state_nxt_s;
      in_ready       <= (state_nxt_s == ST_LEN) || (state_nxt_s == ST_DATA) ||
                        (state_nxt_s == ST_CHK);
      mem_chipselect <= (state_nxt_s == ST_WR);
      mem_write      <= (state_nxt_s == ST_WR);
      cpu_hold       <= (state_nxt_s != ST_DONE);
      load_done      <= (state_nxt_s == ST_DONE);
      load_error     <= (state_nxt_s == ST_ERR);

      if ((state_r == ST_LEN) && accept_s && !len_bad_s) begin
        len_r       <= in_data[ADDR_W-1:0];
        mem_address <= '0;
      end else if ((state_r == ST_WR) && !last_word_s) begin
        // Hold the final address after the last word instead of wrapping.
        mem_address <= mem_address + ADDR_W'(1);
      end

      if (word_valid_s) begin
        mem_writedata <= word_s;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // Running mod-256 sum of data bytes; LEN is excluded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r <= 8'h00;
    end else if (state_r == ST_LEN) begin
      sum_r <= 8'h00;
    end else if (pack_byte_s) begin
      sum_r <= chk_add(sum_r, in_data);
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes are queued when
// stimulus is issued and a negedge monitor pops and compares on each strobe.
// A second instance with ADDR_W=4 exercises the oversized-LEN error path.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic        cpu_hold, load_done, load_error;

  logic        start4 = 1'b0;
  logic [7:0]  in_data4 = 8'h00;
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  mem_address4;
  logic [31:0] mem_writedata4;
  logic [3:0]  mem_byteenable4;
  logic        mem_chipselect4, mem_write4, mem_clken4;
  logic        cpu_hold4, load_done4, load_error4;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_clken(mem_clken), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error)
  );

  instr_mem_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .in_data(in_data4),
    .in_valid(in_valid4), .in_ready(in_ready4), .mem_address(mem_address4),
    .mem_writedata(mem_writedata4), .mem_byteenable(mem_byteenable4),
    .mem_chipselect(mem_chipselect4), .mem_write(mem_write4),
    .mem_clken(mem_clken4), .cpu_hold(cpu_hold4), .load_done(load_done4),
    .load_error(load_error4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img [256];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          strobes4 = 0;
  int          last_strobe = -1;
  bit          spacing_en = 1'b0;
  bit          gap_mode = 1'b0;
  logic [7:0]  bsum;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (mem_write) begin
      strobes = strobes + 1;
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_write: got addr=%h data=%h, no write expected",
                 mem_address, mem_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_address !== mon_e.addr || mem_writedata !== mon_e.data ||
            mem_chipselect !== 1'b1) begin
          n_err = n_err + 1;
          $display("FAIL write: got addr=%h data=%h cs=%b, expected addr=%h data=%h cs=1",
                   mem_address, mem_writedata, mem_chipselect, mon_e.addr, mon_e.data);
        end
      end
      if (spacing_en && last_strobe >= 0) begin
        n_checks = n_checks + 1;
        if (cyc - last_strobe != 5) begin
          n_err = n_err + 1;
          $display("FAIL strobe_spacing: got %0d cycles, expected 5", cyc - last_strobe);
        end
      end
      last_strobe = cyc;
    end
  end

  always @(negedge clk) if (mem_write4) strobes4 = strobes4 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte and hold it until the edge where in_ready was high.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    bit done;
    int n;
    in_data  = b;
    in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        done = 1'b1;
      end else begin
        n = n + 1;
        if (n > 50) begin
          n_checks = n_checks + 1;
          n_err = n_err + 1;
          $display("FAIL accept_timeout: byte %h not accepted, expected in_ready", b);
          done = 1'b1;
        end
      end
    end
  endtask

  // Data byte with optional idle gap and a stray start pulse during the gap.
  task automatic send_data(input logic [7:0] b);
    int g;
    if (gap_mode) begin
      g = $urandom_range(0, 3);
      in_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        start = (j == 0) && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    bsum = bsum + b;
    send_byte(b);
  endtask

  task automatic wait_last_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) begin
        seen = 1'b1;
        chk("hold_during_last_strobe", 32'(cpu_hold), 32'd1);
      end
    end
    if (!seen) begin
      n_checks = n_checks + 1;
      n_err = n_err + 1;
      $display("FAIL last_strobe_timeout: got no strobe, expected one");
    end
  endtask

  // Full load of img[0..len] after a start; checks the DONE entry cycle.
  task automatic load_image(input logic [7:0] len);
    bsum = 8'h00;
    send_byte(len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(wr_t'{8'(i), img[i]});
      for (int k = 0; k < 4; k++) send_data(img[i][8*k +: 8]);
    end
    wait_last_strobe();
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(bsum);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    chk("cpu_hold_after_load", 32'(cpu_hold), 32'd0);
    chk("load_done_after_load", 32'(load_done), 32'd1);
    chk("load_error_after_load", 32'(load_error), 32'd0);
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_write", 32'({mem_write, mem_chipselect}), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_flags", 32'({load_done, load_error}), 32'd0);
    chk("rst_byteenable", 32'(mem_byteenable), 32'h0000000F);
    chk("rst_clken", 32'(mem_clken), 32'd1);
  endtask

  initial begin
    int s0;
    bit seen;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals();

    // Two-word image.
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    s0 = strobes;
    @(posedge clk); #1;
    pulse_start();
    load_image(8'h01);
    chk("two_word_strobes", 32'(strobes - s0), 32'd2);

    // Full 256-word image, in_valid held high, strobes 5 cycles apart.
    for (int i = 0; i < 256; i++)
      img[i] = {8'(i), 8'(255 - i), 8'(i * 3), 8'(i ^ 90)};
    s0 = strobes;
    last_strobe = -1;
    spacing_en = 1'b1;
    pulse_start();
    load_image(8'hFF);
    spacing_en = 1'b0;
    chk("full_strobes", 32'(strobes - s0), 32'd256);
    chk("full_final_addr", 32'(mem_address), 32'd255);

    // Start from DONE re-enters LEN with hold and flags updated together.
    pulse_start();
    @(negedge clk);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart_load_done", 32'(load_done), 32'd0);

    // Gapped stream with stray start pulses mid-load.
    img[0] = 32'hCAFEF00D;
    img[1] = 32'h0BADC0DE;
    img[2] = 32'h55AA33CC;
    @(posedge clk); #1;
    gap_mode = 1'b1;
    s0 = strobes;
    load_image(8'h02);
    gap_mode = 1'b0;
    chk("gap_strobes", 32'(strobes - s0), 32'd3);
    chk("gap_final_addr", 32'(mem_address), 32'd2);

    // Reset after LEN plus five data bytes of an N=2 load.
    img[0] = 32'hA1B2C3D4;
    s0 = strobes;
    pulse_start();
    bsum = 8'h00;
    send_byte(8'h01);
    exp_q.push_back(wr_t'{8'h00, img[0]});
    for (int k = 0; k < 4; k++) send_data(img[0][8*k +: 8]);
    send_data(8'h77);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals();
    chk("partial_strobes", 32'(strobes - s0), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals();
    img[0] = 32'h0F1E2D3C;
    @(posedge clk); #1;
    pulse_start();
    load_image(8'h00);

    // Narrow instance: LEN equal to depth is rejected without strobes.
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    in_data4 = 8'h10;
    in_valid4 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      seen = in_ready4;
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    chk("n4_len_accepted", 32'(seen), 32'd1);
    @(negedge clk);
    chk("n4_load_error", 32'(load_error4), 32'd1);
    chk("n4_cpu_hold", 32'(cpu_hold4), 32'd1);
    chk("n4_in_ready", 32'(in_ready4), 32'd0);
    chk("n4_strobes", 32'(strobes4), 32'd0);
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    chk("n4_restart_error_clear", 32'(load_error4), 32'd0);
    chk("n4_restart_in_ready", 32'(in_ready4), 32'd1);
    // LEN = depth-1 is legal and moves on to DATA.
    in_data4 = 8'h0F;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("n4_len_max_no_error", 32'(load_error4), 32'd0);
    chk("n4_len_max_in_data", 32'(in_ready4), 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Correct and wrong trailer bytes.
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      pulse_start();
      send_byte(8'h00);
      exp_q.push_back(wr_t'{8'h00, 32'h04030201});
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      wait_last_strobe();
      send_byte((t == 0) ? 8'h0A : 8'h0B);
      in_valid = 1'b0;
      @(negedge clk);
      chk("chk_load_done", 32'(load_done), (t == 0) ? 32'd1 : 32'd0);
      chk("chk_load_error", 32'(load_error), (t == 0) ? 32'd0 : 32'd1);
      chk("chk_cpu_hold", 32'(cpu_hold), (t == 0) ? 32'd0 : 32'd1);
    end
`endif

    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
